// File: rtl/pipe_stage_sequencer.sv
// pipe_stage_sequencer: D/E/M/W stage-register sequencer for a five-stage
// in-order pipeline. Applies stall and flush requests to the stage registers,
// derives the write-back address/enable from the M stage, and keeps stall
// statistics (saturating total count, consecutive count, sticky timeout).
module pipe_stage_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       stall_in,
  input  logic       flush,
  input  logic       f_valid,
  input  logic [5:0] f_ops,
  input  logic [4:0] f_rs,
  input  logic [4:0] f_rt,
  input  logic [4:0] f_rd,
  output logic [5:0] d_ops,
  output logic [5:0] e_ops,
  output logic [5:0] m_ops,
  output logic [4:0] d_rs,
  output logic [4:0] d_rt,
  output logic [4:0] d_rd,
  output logic [4:0] e_rs,
  output logic [4:0] e_rt,
  output logic [4:0] e_rd,
  output logic       m_valid,
  output logic       e_valid,
  output logic       d_valid,
  output logic [4:0] wb_addr,
  output logic       wb_en,
  output logic       fetch_hold,
  output logic [7:0] stall_count,
  output logic       stall_timeout
);

  // Class-bit positions inside the 6-bit ops vector {alu,imm,shift,mem,write,jump}.
  localparam int OP_ALU   = 5;
  localparam int OP_IMM   = 4;
  localparam int OP_SHIFT = 3;
  localparam int OP_MEM   = 2;
  localparam int OP_WRITE = 1;

  typedef struct packed {
    logic       valid;
    logic [5:0] ops;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // D and E keep full instruction records; M only needs what W consumes.
  stage_t     r_d;
  stage_t     r_e;
  logic       r_m_valid;
  logic [5:0] r_m_ops;
  logic [4:0] r_m_rt;
  logic [4:0] r_m_rd;
  logic [4:0] r_wb_addr;
  logic       r_wb_en;
  logic [7:0] r_stall_count;
  logic [4:0] r_consec;
  logic       r_timeout;

  stage_t     w_fetch;
  stage_t     w_d_next;
  stage_t     w_e_next;
  logic [4:0] w_wb_addr;
  logic       w_wb_en;

  // Next-state selection for D and E, plus write-back decode of the M stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_fetch   = BUBBLE;
    w_d_next  = BUBBLE;
    w_e_next  = BUBBLE;
    w_wb_addr = 5'd0;
    w_wb_en   = 1'b0;

    // An invalid fetch slot enters as a bubble whatever its fields contain.
    if (f_valid) begin
      w_fetch = '{valid: 1'b1, ops: f_ops, rs: f_rs, rt: f_rt, rd: f_rd};
    end

    // Flush kills the incoming fetch and wins over stall for D.
    if (flush) begin
      w_d_next = BUBBLE;
    end else if (stall_in) begin
      w_d_next = r_d;
    end else begin
      w_d_next = w_fetch;
    end

    // A stall inserts a bubble into E while D holds.
    if (stall_in) begin
      w_e_next = BUBBLE;
    end else begin
      w_e_next = r_d;
    end

    // I-type non-shift instructions target rt; everything else targets rd.
    w_wb_addr = (r_m_ops[OP_IMM] && !r_m_ops[OP_SHIFT]) ? r_m_rt : r_m_rd;
    // r0 is hard-wired zero, so a write to it is suppressed.
    w_wb_en   = r_m_valid
              && (r_m_ops[OP_ALU] || (r_m_ops[OP_MEM] && !r_m_ops[OP_WRITE]))
              && (w_wb_addr != 5'd0);
  end

  // Stage registers: all four stages advance on the same edge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      r_d       <= BUBBLE;
      r_e       <= BUBBLE;
      r_m_valid <= 1'b0;
      r_m_ops   <= 6'd0;
      r_m_rt    <= 5'd0;
      r_m_rd    <= 5'd0;
      r_wb_addr <= 5'd0;
      r_wb_en   <= 1'b0;
    end else begin
      r_d       <= w_d_next;
      r_e       <= w_e_next;
      r_m_valid <= r_e.valid;
      r_m_ops   <= r_e.ops;
      r_m_rt    <= r_e.rt;
      r_m_rd    <= r_e.rd;
      r_wb_addr <= w_wb_addr;
      r_wb_en   <= w_wb_en;
    end
  end

  // Stall statistics: saturating total, consecutive run length, sticky timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= 8'd0;
      r_consec      <= 5'd0;
      r_timeout     <= 1'b0;
    end else begin
      if (stall_in && (r_stall_count != 8'hFF)) begin
        r_stall_count <= r_stall_count + 8'd1;
      end
      if (!stall_in) begin
        r_consec <= 5'd0;
      end else if (r_consec != 5'h1F) begin
        r_consec <= r_consec + 5'd1;
      end
      // The run reaches 16 on this edge; the flag stays up until reset.
      if (stall_in && (r_consec == 5'd15)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign d_valid       = r_d.valid;
  assign d_ops         = r_d.ops;
  assign d_rs          = r_d.rs;
  assign d_rt          = r_d.rt;
  assign d_rd          = r_d.rd;
  assign e_valid       = r_e.valid;
  assign e_ops         = r_e.ops;
  assign e_rs          = r_e.rs;
  assign e_rt          = r_e.rt;
  assign e_rd          = r_e.rd;
  assign m_valid       = r_m_valid;
  assign m_ops         = r_m_ops;
  assign wb_addr       = r_wb_addr;
  assign wb_en         = r_wb_en;
  // A flush redirects fetch, so fetch may advance even while stalled.
  assign fetch_hold    = stall_in && !flush && !reset;
  assign stall_count   = r_stall_count;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// tb_pipe_stage_sequencer: directed bench for pipe_stage_sequencer. Expected
// write-backs (address and arrival cycle) are queued when an instruction is
// fed; a negedge monitor pops and compares them as W produces writes.
module tb_pipe_stage_sequencer;

  localparam logic [5:0] OPS_ALU   = 6'b100000;
  localparam logic [5:0] OPS_ADDI  = 6'b110000;
  localparam logic [5:0] OPS_SLL   = 6'b111000;
  localparam logic [5:0] OPS_LOAD  = 6'b010100;
  localparam logic [5:0] OPS_STORE = 6'b010110;
  localparam logic [5:0] OPS_JUMP  = 6'b000001;

  logic       clock;
  logic       reset;
  logic       stall_in;
  logic       flush;
  logic       f_valid;
  logic [5:0] f_ops;
  logic [4:0] f_rs, f_rt, f_rd;
  logic [5:0] d_ops, e_ops, m_ops;
  logic [4:0] d_rs, d_rt, d_rd, e_rs, e_rt, e_rd;
  logic       m_valid, e_valid, d_valid;
  logic [4:0] wb_addr;
  logic       wb_en;
  logic       fetch_hold;
  logic [7:0] stall_count;
  logic       stall_timeout;

  typedef struct {
    logic [4:0] addr;
    int         due;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      cyc        = 0;
  int      n_cmp      = 0;
  int      n_bad      = 0;
  int      exp_stalls = 0;

  pipe_stage_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .stall_in     (stall_in),
    .flush        (flush),
    .f_valid      (f_valid),
    .f_ops        (f_ops),
    .f_rs         (f_rs),
    .f_rt         (f_rt),
    .f_rd         (f_rd),
    .d_ops        (d_ops),
    .e_ops        (e_ops),
    .m_ops        (m_ops),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_rd         (d_rd),
    .e_rs         (e_rs),
    .e_rt         (e_rt),
    .e_rd         (e_rd),
    .m_valid      (m_valid),
    .e_valid      (e_valid),
    .d_valid      (d_valid),
    .wb_addr      (wb_addr),
    .wb_en        (wb_en),
    .fetch_hold   (fetch_hold),
    .stall_count  (stall_count),
    .stall_timeout(stall_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to time-stamp expected write-backs.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction for a single edge; queue its write-back if it writes.
  task automatic issue(input logic [5:0] ops, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic valid, input logic writes,
                       input logic [4:0] addr, input int extra);
    f_ops   = ops;
    f_rs    = rs;
    f_rt    = rt;
    f_rd    = rd;
    f_valid = valid;
    if (writes) sb.push_back('{addr, cyc + 4 + extra});
    step();
    f_valid = 1'b0;
    f_ops   = 6'd0;
    f_rs    = 5'd0;
    f_rt    = 5'd0;
    f_rd    = 5'd0;
  endtask

  // Write-back monitor: every write must match the head of the queue in address and cycle.
  always @(negedge clock) begin
    if (wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {27'd0, wb_addr}, 32'd0);
        check("wb_en_unexpected", {31'd0, wb_en}, 32'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
        check("wb_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      wb_exp_t e;
      e = sb.pop_front();
      check("wb_missing", {31'd0, wb_en}, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected below 2000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with stall and junk fetch asserted: reset must win.
    reset    = 1'b1;
    stall_in = 1'b1;
    flush    = 1'b0;
    f_valid  = 1'b1;
    f_ops    = OPS_ALU;
    f_rs     = 5'd7;
    f_rt     = 5'd7;
    f_rd     = 5'd7;
    #1;
    check("rst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
    step();
    step();
    reset    = 1'b0;
    stall_in = 1'b0;
    f_valid  = 1'b0;
    f_ops    = 6'd0;
    f_rs     = 5'd0;
    f_rt     = 5'd0;
    f_rd     = 5'd0;
    #1;
    check("rst_d_valid", {31'd0, d_valid}, 32'd0);
    check("rst_e_valid", {31'd0, e_valid}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_d_ops", {26'd0, d_ops}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_stall_count", {24'd0, stall_count}, 32'd0);
    check("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    check("rst_fetch_hold_off", {31'd0, fetch_hold}, 32'd0);

    // add r3,r1,r2 / addi rt=5 / sll rd=9 back to back.
    issue(OPS_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd3, 0);
    check("add_d_valid", {31'd0, d_valid}, 32'd1);
    check("add_d_ops", {26'd0, d_ops}, {26'd0, OPS_ALU});
    check("add_d_rs", {27'd0, d_rs}, 32'd1);
    check("add_d_rt", {27'd0, d_rt}, 32'd2);
    check("add_d_rd", {27'd0, d_rd}, 32'd3);
    issue(OPS_ADDI, 5'd1, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 0);
    check("add_e_rd", {27'd0, e_rd}, 32'd3);
    check("add_e_rs", {27'd0, e_rs}, 32'd1);
    check("addi_d_rt", {27'd0, d_rt}, 32'd5);
    issue(OPS_SLL, 5'd0, 5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 0);
    check("add_m_ops", {26'd0, m_ops}, {26'd0, OPS_ALU});
    check("add_m_valid", {31'd0, m_valid}, 32'd1);
    check("addi_e_ops", {26'd0, e_ops}, {26'd0, OPS_ADDI});
    check("addi_e_rt", {27'd0, e_rt}, 32'd5);

    // Non-writers: store, jump, alu to r0, invalid slot carrying alu fields.
    issue(OPS_STORE, 5'd2, 5'd6, 5'd6, 1'b1, 1'b0, 5'd0, 0);
    issue(OPS_JUMP, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 5'd0, 0);
    issue(OPS_ALU, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 0);
    issue(OPS_ALU, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 0);
    check("bubble_d_valid", {31'd0, d_valid}, 32'd0);
    check("bubble_d_ops", {26'd0, d_ops}, 32'd0);
    check("bubble_d_rd", {27'd0, d_rd}, 32'd0);

    // Load followed by a one-cycle stall.
    issue(OPS_LOAD, 5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1);
    stall_in = 1'b1;
    #1;
    check("stall_fetch_hold", {31'd0, fetch_hold}, 32'd1);
    step();
    exp_stalls++;
    stall_in = 1'b0;
    check("stall_d_valid", {31'd0, d_valid}, 32'd1);
    check("stall_d_rt", {27'd0, d_rt}, 32'd4);
    check("stall_d_ops", {26'd0, d_ops}, {26'd0, OPS_LOAD});
    check("stall_e_ops", {26'd0, e_ops}, 32'd0);
    check("stall_e_valid", {31'd0, e_valid}, 32'd0);
    check("stall_count_1", {24'd0, stall_count}, exp_stalls);
    step();
    check("load_e_rt", {27'd0, e_rt}, 32'd4);

    // Flush alone: D's instruction proceeds, the fetched one is dropped.
    issue(OPS_ALU, 5'd1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 0);
    flush   = 1'b1;
    f_valid = 1'b1;
    f_ops   = OPS_ALU;
    f_rd    = 5'd7;
    step();
    flush   = 1'b0;
    f_valid = 1'b0;
    f_ops   = 6'd0;
    f_rd    = 5'd0;
    check("flush_d_valid", {31'd0, d_valid}, 32'd0);
    check("flush_e_valid", {31'd0, e_valid}, 32'd1);
    check("flush_e_rd", {27'd0, e_rd}, 32'd6);

    // Flush and stall together: both D and E become bubbles, fetch not held.
    issue(OPS_ALU, 5'd1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd0, 0);
    flush    = 1'b1;
    stall_in = 1'b1;
    f_valid  = 1'b1;
    f_ops    = OPS_ALU;
    f_rd     = 5'd10;
    #1;
    check("fs_fetch_hold", {31'd0, fetch_hold}, 32'd0);
    step();
    exp_stalls++;
    check("fs_d_valid", {31'd0, d_valid}, 32'd0);
    check("fs_e_valid", {31'd0, e_valid}, 32'd0);
    check("fs_fetch_hold_next", {31'd0, fetch_hold}, 32'd0);
    flush    = 1'b0;
    stall_in = 1'b0;
    f_valid  = 1'b0;
    f_ops    = 6'd0;
    f_rd     = 5'd0;
    check("stall_count_2", {24'd0, stall_count}, exp_stalls);
    for (int i = 0; i < 6; i++) step();

    // Long stall: saturation at 255 and timeout on the 16th consecutive cycle.
    stall_in = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_stalls++;
      if (i == 15) check("timeout_15", {31'd0, stall_timeout}, 32'd0);
      if (i == 16) check("timeout_16", {31'd0, stall_timeout}, 32'd1);
      if (i == 252 || i == 253 || i == 300)
        check("stall_count_sat", {24'd0, stall_count}, (exp_stalls > 255) ? 255 : exp_stalls);
    end
    stall_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("timeout_sticky", {31'd0, stall_timeout}, 32'd1);
    check("stall_count_hold", {24'd0, stall_count}, 32'd255);

    // Reset with an alu op in M and a store in E: nothing may write back.
    issue(OPS_ALU, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 5'd0, 0);
    issue(OPS_STORE, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 5'd0, 0);
    step();
    check("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
    check("pre_rst_e_ops", {26'd0, e_ops}, {26'd0, OPS_STORE});
    reset    = 1'b1;
    stall_in = 1'b1;
    flush    = 1'b1;
    step();
    check("mid_d_valid", {31'd0, d_valid}, 32'd0);
    check("mid_e_valid", {31'd0, e_valid}, 32'd0);
    check("mid_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_wb_en", {31'd0, wb_en}, 32'd0);
    check("mid_timeout", {31'd0, stall_timeout}, 32'd0);
    check("mid_stall_count", {24'd0, stall_count}, 32'd0);
    check("mid_fetch_hold", {31'd0, fetch_hold}, 32'd0);
    reset    = 1'b0;
    stall_in = 1'b0;
    flush    = 1'b0;

    // Drain and confirm every queued write-back appeared.
    for (int i = 0; i < 8; i++) step();
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
